// File: rtl/ncc_desc_loader.sv
// Descriptor loader for the NCC PE grid: unpacks streamed pixel words, converts each
// pixel to a log2 fixed-point code and stores it row-major in a DESC_DIM x DESC_DIM bank.
module ncc_desc_loader #(
    parameter int DESC_DIM = 16,
    parameter int PIX_W    = 8,
    parameter int WORD_W   = 32,
    localparam int PPW     = WORD_W / PIX_W,
    localparam int NPIX    = DESC_DIM * DESC_DIM,
    localparam int NWORDS  = NPIX / PPW,
    localparam int CNT_W   = $clog2(NWORDS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [WORD_W-1:0]   in_data,
    output logic                in_ready,
    output logic [NPIX*33-1:0]  desc_pixels,
    output logic [NPIX-1:0]     desc_zero_mask,
    output logic                desc_valid,
    output logic                busy,
    output logic [CNT_W-1:0]    word_count
);

    // Handshake: a word transfers on a rising edge where in_valid && in_ready;
    // in_ready depends on state only, so in_valid may be raised freely.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [NPIX*33-1:0]   desc_q, desc_d;
    logic [NPIX-1:0]      mask_q, mask_d;
    logic                 accept;
    logic [PIX_W-1:0]     pix;

    // Leading-one position becomes the integer part; the bits below it are
    // left-aligned into the 27-bit fraction. Both 0 and 1 map to code 0.
    function automatic logic [32:0] to_code(input logic [PIX_W-1:0] v);
        logic [4:0]        idx;
        logic [PIX_W+26:0] ext;
        logic [PIX_W+26:0] shifted;
        idx = '0;
        for (int i = 0; i < PIX_W; i++) begin
            if (v[i]) idx = 5'(i);
        end
        ext     = {v, 27'd0};
        shifted = ext << (6'(PIX_W) - {1'b0, idx});
        return {1'b0, idx, shifted[PIX_W+26 -: 27]};
    endfunction

    assign accept = in_valid && (state_q == LOAD);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        desc_d  = desc_q;
        mask_d  = mask_q;
        pix     = '0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    count_d = count_q + 1'b1;
                    if (count_q == CNT_W'(NWORDS - 1)) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Linear indexing lets a word straddle a grid row boundary.
        if (accept) begin
            for (int k = 0; k < NPIX; k++) begin
                if (CNT_W'(k / PPW) == count_q) begin
                    pix = in_data[WORD_W-1-(k%PPW)*PIX_W -: PIX_W];
                    desc_d[33*k +: 33] = to_code(pix);
                    mask_d[k]          = (pix == '0);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            desc_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            desc_q  <= desc_d;
            mask_q  <= mask_d;
        end
    end

    assign in_ready       = (state_q == LOAD);
    assign busy           = (state_q == LOAD);
    assign desc_valid     = (state_q == DONE);
    assign word_count     = count_q;
    assign desc_pixels    = desc_q;
    assign desc_zero_mask = mask_q;

endmodule

// File: doc/ncc_desc_loader.md
Name: ncc_desc_loader

Overview:
- Parametrised descriptor loader for the NCC PE grid. Accepts packed pixel words over a valid/ready stream and converts each pixel to the log2 fixed-point code {sign, 5-bit int, 27-bit frac}.
- Writes the codes row-major into a DESC_DIM x DESC_DIM bank of descriptor registers that feed the processing elements.
- Adds start/reload control, a zero-pixel mask, progress count and a descriptor-valid flag.

Parameters:
- DESC_DIM, 16, grid rows = grid columns.
- PIX_W, 8, bits per unsigned pixel; PIX_W <= 27.
- WORD_W, 32, input word width; PPW = WORD_W/PIX_W pixels per word.
- Constraint: DESC_DIM*DESC_DIM must be divisible by PPW. NWORDS = DESC_DIM*DESC_DIM/PPW.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle request to (re)load a descriptor.
- in_valid  in  1  in_data holds a word.
- in_data  in  WORD_W  packed pixels; bits [WORD_W-1 -: PIX_W] are the lowest-index pixel.
- in_ready  out  1  loader accepts a word this cycle.
- desc_pixels  out  DESC_DIM*DESC_DIM*33  flattened codes; entry k (row k/DESC_DIM, col k%DESC_DIM) occupies bits [33k+32:33k].
- desc_zero_mask  out  DESC_DIM*DESC_DIM  bit k = 1 when pixel k was 0.
- desc_valid  out  1  full descriptor loaded.
- busy  out  1  in LOAD state.
- word_count  out  $clog2(NWORDS+1)  words accepted in the current load.

Behaviour:
- Reset: state IDLE. in_ready, busy and desc_valid are 0. word_count is 0. All desc_pixels and desc_zero_mask bits are 0.
- States and transitions:
  - IDLE: start -> LOAD.
  - LOAD: accepting the final word (word_count == NWORDS-1) -> DONE.
  - DONE: start -> LOAD.
- On the start transition: word_count <= 0 and desc_valid <= 0. Register contents are retained until overwritten.
- start is ignored in LOAD.
- Outputs by state:
  - in_ready = 1 exactly in LOAD. Combinational from the state only, never from in_valid.
  - busy = (state == LOAD).
  - desc_valid = (state == DONE), registered.
- A word is accepted on a rising edge with in_valid & in_ready. On that edge:
  - pixels p = 0..PPW-1 are written to linear index word_count*PPW + p;
  - the zero-mask bits are updated for the same indices;
  - word_count increments.
  - Words may span grid rows, because indexing is linear.
- Timing:
  - An accepted word is visible on desc_pixels the next cycle.
  - desc_valid rises the cycle after the final word is accepted.
  - Minimum load time is NWORDS cycles, plus 1 cycle from start to LOAD.
- Backpressure: in_valid low in LOAD stalls the load. There is no timeout, and state and count hold.
- Conversion, per pixel v (zero-extended):
  - idx = index of the most-significant 1.
  - frac = bits below the leading one, left-aligned into 27 bits, with the remainder zero-filled.
  - code = {1'b0, idx[4:0], frac}.
  - v == 0 gives code 0 and mask bit 1. Otherwise the mask bit is 0.
  - v == 1 also gives code 0, with mask bit 0.
- The conversion is combinational between in_data and the register write. No extra pipeline latency.
- Simultaneous events:
  - start and in_valid in the same IDLE or DONE cycle: the word is not accepted (in_ready = 0). LOAD begins next cycle.
  - rst asserted mid-LOAD: everything returns to reset values immediately (asynchronous). A partial descriptor is never flagged valid.

Test Plan:
- Reset check: assert rst mid-cycle with arbitrary inputs -> in_ready = 0, desc_valid = 0, word_count = 0, desc_pixels = 0 asynchronously.
- Conversion, default parameters: start, then word 0x80_03_FF_00 with in_valid held. Next cycle:
  - entry 0 = {0, 7, 0};
  - entry 1 = {0, 1, 27'h4000000};
  - entry 2 = {0, 7, 27'h7F00000};
  - entry 3 = 0 with mask[3] = 1, mask[2:0] = 0;
  - word_count = 1.
- Full load, default parameters: start, then 64 back-to-back words with word i = {4{i[7:0]}} ->
  - row r, col c holds the code of (r*4 + c/4);
  - desc_valid = 1 exactly one cycle after the 64th acceptance;
  - in_ready = 0 in DONE.
- Backpressure: during a load, drop in_valid for 5 cycles after word 10 -> word_count holds at 11, no writes occur, and the load completes after the remaining 53 words.
- Reload: from DONE, pulse start together with in_valid -> desc_valid = 0 next cycle, that word is not accepted, and word_count restarts at 0. Writing 1 word changes only entries 0-3; the others retain their old codes.
- Parameter sweep: DESC_DIM = 8, PIX_W = 16, WORD_W = 32 -> NWORDS = 32.
  - 0x0001 maps to code 0 with mask 0.
  - 0xFFFF maps to {0, 15, 27'h7FFF000}.
  - desc_valid after 32 words.
- Reset mid-load: assert rst after 20 words, then start a fresh load -> desc_valid appears only after a complete NWORDS sequence.
